vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 136 +++++++++++++
 tb/tb_vga_sync_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running h/v position counters, sync/blank decode,
// and a configurable output pipeline that keeps sync, data-enable and colour aligned.
module vga_sync_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   COLOR_BITS = 1,
    parameter int   PIPE_DELAY = 1,
    parameter int   CNT_W      = 10,
    parameter int   FRAME_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [3*COLOR_BITS-1:0] pixel,
    output logic [CNT_W-1:0]        hpos,
    output logic [CNT_W-1:0]        vpos,
    output logic                    active,
    output logic                    line_tick,
    output logic                    frame_tick,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic [COLOR_BITS-1:0]   red,
    output logic [COLOR_BITS-1:0]   green,
    output logic [COLOR_BITS-1:0]   blue,
    output logic [FRAME_W-1:0]      frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Timing constants carried one bit wider than the counters so no comparison truncates.
    localparam logic [CNT_W:0] H_MAX = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic [CNT_W:0] V_MAX = (CNT_W+1)'(V_TOTAL - 1);
    localparam logic [CNT_W:0] H_ACT = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] V_ACT = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] H_SS  = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] H_SE  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W:0] V_SS  = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] V_SE  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
            PIPE_DELAY < 1 ||
            longint'(H_TOTAL - 1) >= (longint'(1) << CNT_W) ||
            longint'(V_TOTAL - 1) >= (longint'(1) << CNT_W)) begin : g_bad_params
            $error("vga_sync_gen: illegal timing parameters");
        end
    endgenerate

    logic [CNT_W:0] h_ext;
    logic [CNT_W:0] v_ext;
    logic           h_wrap;
    logic           v_wrap;
    logic           hs_raw;
    logic           vs_raw;

    assign h_ext  = {1'b0, hpos};
    assign v_ext  = {1'b0, vpos};
    assign h_wrap = (h_ext == H_MAX);
    assign v_wrap = (v_ext == V_MAX);

    assign active     = (h_ext < H_ACT) && (v_ext < V_ACT);
    assign hs_raw     = (h_ext >= H_SS && h_ext <= H_SE) ? HSYNC_POL : ~HSYNC_POL;
    assign vs_raw     = (v_ext >= V_SS && v_ext <= V_SE) ? VSYNC_POL : ~VSYNC_POL;
    assign line_tick  = en && (h_ext == H_ACT);
    assign frame_tick = line_tick && (v_ext == V_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            hpos        <= '0;
            vpos        <= '0;
            frame_count <= '0;
        end else if (en) begin
            if (h_wrap) begin
                hpos <= '0;
                if (v_wrap) begin
                    vpos        <= '0;
                    frame_count <= frame_count + 1'b1;
                end else begin
                    vpos <= vpos + 1'b1;
                end
            end else begin
                hpos <= hpos + 1'b1;
            end
        end
    end

    // chain[0] is the raw (undelayed) value, chain[i] is pipeline stage i-1.
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;
    logic [PIPE_DELAY-1:0] act_pipe;
    logic [PIPE_DELAY:0]   hs_chain;
    logic [PIPE_DELAY:0]   vs_chain;
    logic [PIPE_DELAY:0]   act_chain;
    logic                  act_in;

    assign hs_chain  = {hs_pipe, hs_raw};
    assign vs_chain  = {vs_pipe, vs_raw};
    assign act_chain = {act_pipe, active};
    assign act_in    = act_chain[PIPE_DELAY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe  <= {PIPE_DELAY{~HSYNC_POL}};
            vs_pipe  <= {PIPE_DELAY{~VSYNC_POL}};
            act_pipe <= '0;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else if (en) begin
            hs_pipe  <= hs_chain[PIPE_DELAY-1:0];
            vs_pipe  <= vs_chain[PIPE_DELAY-1:0];
            act_pipe <= act_chain[PIPE_DELAY-1:0];
            // Colour is blanked using the active flag entering the final stage, so it lines up with de.
            red      <= act_in ? pixel[COLOR_BITS-1:0]              : '0;
            green    <= act_in ? pixel[2*COLOR_BITS-1:COLOR_BITS]   : '0;
            blue     <= act_in ? pixel[3*COLOR_BITS-1:2*COLOR_BITS] : '0;
        end
    end

    assign hsync = hs_pipe[PIPE_DELAY-1];
    assign vsync = vs_pipe[PIPE_DELAY-1];
    assign de    = act_pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a tiny 15x8 raster with a two-stage output pipeline.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [2:0] pixel = 3'b111;
    logic [9:0] hpos, vpos;
    logic       active, line_tick, frame_tick, hsync, vsync, de;
    logic       red, green, blue;
    logic [3:0] frame_count;

    int tests = 0;
    int fails = 0;

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .COLOR_BITS(1), .PIPE_DELAY(2), .CNT_W(10), .FRAME_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pixel(pixel),
        .hpos(hpos), .vpos(vpos), .active(active),
        .line_tick(line_tick), .frame_tick(frame_tick),
        .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // k = enabled edges since reset release; expected values derived from the 15x8 raster.
    typedef struct {
        int       k;
        int       h;
        int       v;
        bit       hs;
        bit       vs;
        bit       de;
        bit [2:0] rgb;
        bit       lt;
        bit       ft;
        int       fc;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check_vec(input int i);
        vec_t e;
        e = vecs[i];
        check($sformatf("v%0d_k%0d hpos", i, e.k), 64'(hpos), 64'(e.h));
        check($sformatf("v%0d_k%0d vpos", i, e.k), 64'(vpos), 64'(e.v));
        check($sformatf("v%0d_k%0d hsync", i, e.k), 64'(hsync), 64'(e.hs));
        check($sformatf("v%0d_k%0d vsync", i, e.k), 64'(vsync), 64'(e.vs));
        check($sformatf("v%0d_k%0d de", i, e.k), 64'(de), 64'(e.de));
        check($sformatf("v%0d_k%0d rgb", i, e.k), 64'({blue, green, red}), 64'(e.rgb));
        check($sformatf("v%0d_k%0d line_tick", i, e.k), 64'(line_tick), 64'(e.lt));
        check($sformatf("v%0d_k%0d frame_tick", i, e.k), 64'(frame_tick), 64'(e.ft));
        check($sformatf("v%0d_k%0d frame_count", i, e.k), 64'(frame_count), 64'(e.fc));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " hpos"}, 64'(hpos), 64'd0);
        check({tag, " vpos"}, 64'(vpos), 64'd0);
        check({tag, " frame_count"}, 64'(frame_count), 64'd0);
        check({tag, " hsync"}, 64'(hsync), 64'd1);
        check({tag, " vsync"}, 64'(vsync), 64'd1);
        check({tag, " de"}, 64'(de), 64'd0);
        check({tag, " rgb"}, 64'({blue, green, red}), 64'd0);
        check({tag, " active"}, 64'(active), 64'd1);
        check({tag, " line_tick"}, 64'(line_tick), 64'd0);
        check({tag, " frame_tick"}, 64'(frame_tick), 64'd0);
    endtask

    initial begin
        int idx;
        int n_de, n_lt, n_ft, n_hs, n_vs, n_badrgb, ft_h, ft_v;
        int cyc, last_wrap, period, n_wraps, bad_hold, bad_tick, lt_seen;
        logic [3:0] prev_fc;
        logic [31:0] snap;
        logic prev_en;

        //              k    h  v  hs vs de rgb lt ft fc
        vecs[0]  = '{  0,   0, 0, 1, 1, 0, 3'd0, 0, 0, 0};
        vecs[1]  = '{  1,   1, 0, 1, 1, 0, 3'd0, 0, 0, 0};
        vecs[2]  = '{  2,   2, 0, 1, 1, 1, 3'd7, 0, 0, 0};
        vecs[3]  = '{  8,   8, 0, 1, 1, 1, 3'd7, 1, 0, 0};
        vecs[4]  = '{  9,   9, 0, 1, 1, 1, 3'd7, 0, 0, 0};
        vecs[5]  = '{ 10,  10, 0, 1, 1, 0, 3'd0, 0, 0, 0};
        vecs[6]  = '{ 12,  12, 0, 0, 1, 0, 3'd0, 0, 0, 0};
        vecs[7]  = '{ 14,  14, 0, 0, 1, 0, 3'd0, 0, 0, 0};
        vecs[8]  = '{ 15,   0, 1, 1, 1, 0, 3'd0, 0, 0, 0};
        vecs[9]  = '{ 16,   1, 1, 1, 1, 0, 3'd0, 0, 0, 0};
        vecs[10] = '{ 17,   2, 1, 1, 1, 1, 3'd7, 0, 0, 0};
        vecs[11] = '{ 68,   8, 4, 1, 1, 0, 3'd0, 1, 1, 0};
        vecs[12] = '{ 75,   0, 5, 1, 1, 0, 3'd0, 0, 0, 0};
        vecs[13] = '{ 77,   2, 5, 1, 0, 0, 3'd0, 0, 0, 0};
        vecs[14] = '{106,   1, 7, 1, 0, 0, 3'd0, 0, 0, 0};
        vecs[15] = '{107,   2, 7, 1, 1, 0, 3'd0, 0, 0, 0};
        vecs[16] = '{119,  14, 7, 0, 1, 0, 3'd0, 0, 0, 0};
        vecs[17] = '{120,   0, 0, 1, 1, 0, 3'd0, 0, 0, 1};
        vecs[18] = '{122,   2, 0, 1, 1, 1, 3'd7, 0, 0, 1};

        // Reset held across several edges.
        #32;
        check_reset_values("in_reset");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idx = 0;
        for (int k = 0; k <= 122; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            while (idx < NV && vecs[idx].k == k) begin
                check_vec(idx);
                idx++;
            end
        end

        // One full frame of statistics from an arbitrary phase.
        n_de = 0; n_lt = 0; n_ft = 0; n_hs = 0; n_vs = 0; n_badrgb = 0; ft_h = -1; ft_v = -1;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk);
            #1;
            if (de) n_de++;
            if ({blue, green, red} != (de ? 3'b111 : 3'b000)) n_badrgb++;
            if (line_tick) n_lt++;
            if (frame_tick) begin
                n_ft++;
                ft_h = int'(hpos);
                ft_v = int'(vpos);
            end
            if (!hsync) n_hs++;
            if (!vsync) n_vs++;
        end
        check("frame de cycles", 64'(n_de), 64'd32);
        check("frame rgb vs de errors", 64'(n_badrgb), 64'd0);
        check("frame line_ticks", 64'(n_lt), 64'd8);
        check("frame frame_ticks", 64'(n_ft), 64'd1);
        check("frame_tick hpos", 64'(ft_h), 64'd8);
        check("frame_tick vpos", 64'(ft_v), 64'd4);
        check("frame hsync low cycles", 64'(n_hs), 64'd24);
        check("frame vsync low cycles", 64'(n_vs), 64'd30);

        // en toggling 1,0,1,0: frame period doubles, state holds on en=0.
        cyc = 0; last_wrap = -1; period = 0; n_wraps = 0;
        bad_hold = 0; bad_tick = 0; lt_seen = 0;
        prev_fc = frame_count;
        for (int c = 0; c < 600; c++) begin
            en = (c % 2 == 0);
            #1;
            if (!en && (line_tick || frame_tick)) bad_tick++;
            if (en && line_tick) lt_seen++;
            snap = {hpos, vpos, hsync, vsync, de, red, green, blue, frame_count, active};
            prev_en = en;
            @(posedge clk);
            cyc++;
            #1;
            if (!prev_en && snap != {hpos, vpos, hsync, vsync, de, red, green, blue, frame_count, active})
                bad_hold++;
            if (frame_count != prev_fc) begin
                if (last_wrap >= 0 && n_wraps == 1) period = cyc - last_wrap;
                last_wrap = cyc;
                n_wraps++;
                prev_fc = frame_count;
            end
        end
        en = 1'b1;
        check("en toggle frame period", 64'(period), 64'd240);
        check("en=0 hold violations", 64'(bad_hold), 64'd0);
        check("en=0 tick violations", 64'(bad_tick), 64'd0);
        check("en=1 line ticks seen", 64'(lt_seen > 0), 64'd1);

        // 16 frames from reset: frame_count counts 1..15 then wraps to 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            repeat (120) @(posedge clk);
            #1;
            check($sformatf("frame_count after %0d frames", n), 64'(frame_count), 64'(n % 16));
        end

        // Mid-frame asynchronous reset at (5,2), observed before the next edge.
        repeat (155) @(posedge clk);
        #1;
        check("pre-reset hpos", 64'(hpos), 64'd5);
        check("pre-reset vpos", 64'(vpos), 64'd2);
        check("pre-reset frame_count", 64'(frame_count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset hpos", 64'(hpos), 64'd1);
        check("post-reset vpos", 64'(vpos), 64'd0);
        check("post-reset frame_count", 64'(frame_count), 64'd0);
        check("post-reset hsync", 64'(hsync), 64'd1);
        check("post-reset de", 64'(de), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
